// File: rtl/shared_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shared_mem_pkg: requester IDs, read-tag type and unitRAM defaults  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package shared_mem_pkg;

   localparam int DEF_WORD_WIDTH = 4;
   localparam int DEF_ADDR_WIDTH = 3;
   localparam int DEF_RD_LATENCY = 1;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   typedef struct packed {
      logic valid;
      logic id;
   } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter2: two-way round-robin arbiter with a force-off input    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_arbiter2
   import shared_mem_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [1:0] req_i,
   input  logic       force_off_i,
   output logic       pick_valid_o,
   output logic       pick_id_o,
   output logic [1:0] gnt_o
);

   logic favour_q;
   logic favour_d;

   // The pick ignores force_off so the caller can inspect it before vetoing.
   assign pick_valid_o = req_i[0] | req_i[1];
   assign pick_id_o    = (req_i == 2'b11) ? favour_q : (req_i[1] ? REQ_B : REQ_A);

   assign gnt_o[0] = pick_valid_o & ~force_off_i & (pick_id_o == REQ_A);
   assign gnt_o[1] = pick_valid_o & ~force_off_i & (pick_id_o == REQ_B);

   always_comb begin
      favour_d = favour_q;
      if (gnt_o[0] | gnt_o[1]) begin
         favour_d = ~pick_id_o;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         favour_q <= REQ_A;
      end else begin
         favour_q <= favour_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/shared_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shared_ram_arbiter: shares one simple-dual-port RAM between two    |
// | writers and two readers; read data returned in grant order.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module shared_ram_arbiter
   import shared_mem_pkg::*;
#(
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int RD_LATENCY = DEF_RD_LATENCY
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  wa_req_i,
   input  logic [ADDR_WIDTH-1:0] wa_addr_i,
   input  logic [WORD_WIDTH-1:0] wa_data_i,
   output logic                  wa_gnt_o,
   input  logic                  wb_req_i,
   input  logic [ADDR_WIDTH-1:0] wb_addr_i,
   input  logic [WORD_WIDTH-1:0] wb_data_i,
   output logic                  wb_gnt_o,
   input  logic                  ra_req_i,
   input  logic [ADDR_WIDTH-1:0] ra_addr_i,
   output logic                  ra_gnt_o,
   output logic                  ra_valid_o,
   output logic [WORD_WIDTH-1:0] ra_data_o,
   input  logic                  rb_req_i,
   input  logic [ADDR_WIDTH-1:0] rb_addr_i,
   output logic                  rb_gnt_o,
   output logic                  rb_valid_o,
   output logic [WORD_WIDTH-1:0] rb_data_o,
   output logic                  ram_wr_en_o,
   output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
   output logic [WORD_WIDTH-1:0] ram_wr_data_o,
   output logic [ADDR_WIDTH-1:0] ram_rd_address_o,
   input  logic [WORD_WIDTH-1:0] ram_rd_data_i
);

   logic [1:0]            wr_req;
   logic [1:0]            rd_req;
   logic [1:0]            wr_gnt;
   logic [1:0]            rd_gnt;
   logic                  wr_pick_valid;
   logic                  wr_pick_id;
   logic                  rd_pick_valid;
   logic                  rd_pick_id;
   logic [ADDR_WIDTH-1:0] wr_addr_sel;
   logic [WORD_WIDTH-1:0] wr_data_sel;
   logic [ADDR_WIDTH-1:0] rd_addr_sel;
   logic                  collision;

   logic                  coll_q, coll_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [WORD_WIDTH-1:0] wr_data_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   rd_tag_t               new_tag;
   rd_tag_t [RD_LATENCY:0] tag_q, tag_d;
   rd_tag_t               tag_out;

   assign wr_req = {wb_req_i, wa_req_i};
   assign rd_req = {rb_req_i, ra_req_i};

   rr_arbiter2 u_wr_arb (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .req_i        (wr_req),
      .force_off_i  (coll_q),
      .pick_valid_o (wr_pick_valid),
      .pick_id_o    (wr_pick_id),
      .gnt_o        (wr_gnt)
   );

   rr_arbiter2 u_rd_arb (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .req_i        (rd_req),
      .force_off_i  (collision),
      .pick_valid_o (rd_pick_valid),
      .pick_id_o    (rd_pick_id),
      .gnt_o        (rd_gnt)
   );

   assign wr_addr_sel = (wr_pick_id == REQ_B) ? wb_addr_i : wa_addr_i;
   assign wr_data_sel = (wr_pick_id == REQ_B) ? wb_data_i : wa_data_i;
   assign rd_addr_sel = (rd_pick_id == REQ_B) ? rb_addr_i : ra_addr_i;

   // While the flag is up the read owns the cycle, so no new collision can form.
   assign collision = ~coll_q & wr_pick_valid & rd_pick_valid & (wr_addr_sel == rd_addr_sel);
   assign coll_d    = collision;
   assign wr_en_d   = wr_gnt[0] | wr_gnt[1];

   assign new_tag.valid = rd_gnt[0] | rd_gnt[1];
   assign new_tag.id    = rd_pick_id;
   assign tag_d         = {tag_q[RD_LATENCY-1:0], new_tag};

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         coll_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
         tag_q     <= '0;
      end else begin
         coll_q  <= coll_d;
         wr_en_q <= wr_en_d;
         tag_q   <= tag_d;
         if (wr_en_d) begin
            wr_addr_q <= wr_addr_sel;
            wr_data_q <= wr_data_sel;
         end
         if (new_tag.valid) begin
            rd_addr_q <= rd_addr_sel;
         end
      end
   end

   assign tag_out = tag_q[RD_LATENCY];

   assign wa_gnt_o         = wr_gnt[0];
   assign wb_gnt_o         = wr_gnt[1];
   assign ra_gnt_o         = rd_gnt[0];
   assign rb_gnt_o         = rd_gnt[1];
   assign ra_valid_o       = tag_out.valid & (tag_out.id == REQ_A);
   assign rb_valid_o       = tag_out.valid & (tag_out.id == REQ_B);
   assign ra_data_o        = ram_rd_data_i;
   assign rb_data_o        = ram_rd_data_i;
   assign ram_wr_en_o      = wr_en_q;
   assign ram_wr_address_o = wr_addr_q;
   assign ram_wr_data_o    = wr_data_q;
   assign ram_rd_address_o = rd_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_shared_ram_arbiter: bench for shared_ram_arbiter, RD_LATENCY 1/2 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_shared_ram_arbiter;

   localparam int WW = 4;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          wa_req, wb_req, ra_req, rb_req;
   logic [AW-1:0] wa_addr, wb_addr, ra_addr, rb_addr;
   logic [WW-1:0] wa_data, wb_data;

   // Index 0: RD_LATENCY=1 instance, index 1: RD_LATENCY=2 instance.
   logic [1:0]         wa_gnt, wb_gnt, ra_gnt, rb_gnt, ra_valid, rb_valid, ram_wr_en;
   logic [1:0][WW-1:0] ra_data, rb_data, ram_wr_data, ram_rd_data;
   logic [1:0][AW-1:0] ram_wr_addr, ram_rd_addr;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      logic [WW-1:0] mem [8];
      logic [WW-1:0] rd_pipe [2];

      always @(posedge clk) begin
         if (ram_wr_en[k]) mem[ram_wr_addr[k]] <= ram_wr_data[k];
         rd_pipe[0] <= mem[ram_rd_addr[k]];
         rd_pipe[1] <= rd_pipe[0];
      end
      assign ram_rd_data[k] = rd_pipe[k];

      shared_ram_arbiter #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .RD_LATENCY(k + 1)) u_dut (
         .clk_i            (clk),
         .reset_i          (rst),
         .wa_req_i         (wa_req),
         .wa_addr_i        (wa_addr),
         .wa_data_i        (wa_data),
         .wa_gnt_o         (wa_gnt[k]),
         .wb_req_i         (wb_req),
         .wb_addr_i        (wb_addr),
         .wb_data_i        (wb_data),
         .wb_gnt_o         (wb_gnt[k]),
         .ra_req_i         (ra_req),
         .ra_addr_i        (ra_addr),
         .ra_gnt_o         (ra_gnt[k]),
         .ra_valid_o       (ra_valid[k]),
         .ra_data_o        (ra_data[k]),
         .rb_req_i         (rb_req),
         .rb_addr_i        (rb_addr),
         .rb_gnt_o         (rb_gnt[k]),
         .rb_valid_o       (rb_valid[k]),
         .rb_data_o        (rb_data[k]),
         .ram_wr_en_o      (ram_wr_en[k]),
         .ram_wr_address_o (ram_wr_addr[k]),
         .ram_wr_data_o    (ram_wr_data[k]),
         .ram_rd_address_o (ram_rd_addr[k]),
         .ram_rd_data_i    (ram_rd_data[k])
      );
   end

   typedef struct {
      logic [3:0]    req;    // {wa, wb, ra, rb}
      logic [AW-1:0] waa, wba, raa, rba;
      logic [WW-1:0] wad, wbd;
      logic [3:0]    gnt;    // {wa, wb, ra, rb}
      logic          wr_en;
   } vec_t;

   typedef struct {
      logic [WW-1:0] data;
      int            due;
   } exp_t;

   vec_t          tbl [18];
   exp_t          sbq [4][$];   // 2*instance + {0:ra, 1:rb}
   logic [WW-1:0] ref_mem [8];
   int            vec_cnt = 0;
   int            err = 0;

   function automatic vec_t mk(input logic [3:0] req, input logic [AW-1:0] waa, wba, raa, rba,
                               input logic [WW-1:0] wad, wbd, input logic [3:0] gnt, input logic wr_en);
      vec_t v;
      v.req = req; v.waa = waa; v.wba = wba; v.raa = raa; v.rba = rba;
      v.wad = wad; v.wbd = wbd; v.gnt = gnt; v.wr_en = wr_en;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic sb_port(input int k, input logic v, input logic [WW-1:0] d);
      exp_t e;
      if (v) begin
         if (sbq[k].size() == 0) begin
            vec_cnt++;
            err++;
            $display("FAIL sb_unexpected_valid[%0d]: got valid data %0h expected no valid (cycle %0d)", k, d, cyc);
         end else begin
            e = sbq[k].pop_front();
            chk($sformatf("sb_cycle[%0d]", k), cyc, e.due);
            chk($sformatf("sb_data[%0d]", k), {28'd0, d}, {28'd0, e.data});
         end
      end else if (sbq[k].size() != 0 && sbq[k][0].due <= cyc) begin
         vec_cnt++;
         err++;
         $display("FAIL sb_missing_valid[%0d]: got no valid expected data %0h at cycle %0d", k, sbq[k][0].data, sbq[k][0].due);
         void'(sbq[k].pop_front());
      end
   endtask

   // Negedge sample point: score returned reads, then log new grants against the reference memory.
   task automatic sample();
      exp_t e;
      @(negedge clk);
      if (rst) begin
         for (int k = 0; k < 4; k++) sbq[k].delete();
      end else begin
         for (int j = 0; j < 2; j++) begin
            sb_port(2 * j, ra_valid[j], ra_data[j]);
            sb_port(2 * j + 1, rb_valid[j], rb_data[j]);
            if (ra_gnt[j]) begin
               e.data = ref_mem[ra_addr]; e.due = cyc + 2 + j;
               sbq[2 * j].push_back(e);
            end
            if (rb_gnt[j]) begin
               e.data = ref_mem[rb_addr]; e.due = cyc + 2 + j;
               sbq[2 * j + 1].push_back(e);
            end
         end
         if (wa_gnt[0]) ref_mem[wa_addr] = wa_data;
         if (wb_gnt[0]) ref_mem[wb_addr] = wb_data;
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v);
      {wa_req, wb_req, ra_req, rb_req} = v.req;
      wa_addr = v.waa; wb_addr = v.wba; ra_addr = v.raa; rb_addr = v.rba;
      wa_data = v.wad; wb_data = v.wbd;
   endtask

   initial begin
      int ra_i, rb_i;
      vec_t idle;
      idle = mk(4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 1'b0);
      tbl[0]  = mk(4'b0000, 0, 0, 0, 0, 4'h0, 4'h0, 4'b0000, 1'b1);
      tbl[1]  = mk(4'b1000, 3, 0, 0, 0, 4'h5, 4'h0, 4'b1000, 1'b0);
      tbl[2]  = mk(4'b0010, 0, 0, 3, 0, 4'h0, 4'h0, 4'b0010, 1'b1);
      tbl[3]  = mk(4'b0100, 0, 7, 0, 0, 4'h0, 4'hE, 4'b0100, 1'b0);
      tbl[4]  = mk(4'b1100, 0, 1, 0, 0, 4'h1, 4'h2, 4'b1000, 1'b1);
      tbl[5]  = mk(4'b1100, 0, 1, 0, 0, 4'h1, 4'h2, 4'b0100, 1'b1);
      tbl[6]  = mk(4'b1100, 0, 1, 0, 0, 4'h1, 4'h2, 4'b1000, 1'b1);
      tbl[7]  = mk(4'b1100, 0, 1, 0, 0, 4'h1, 4'h2, 4'b0100, 1'b1);
      tbl[8]  = mk(4'b1001, 6, 0, 0, 6, 4'h9, 4'h0, 4'b1000, 1'b1);
      tbl[9]  = mk(4'b1001, 6, 0, 0, 6, 4'h3, 4'h0, 4'b0001, 1'b1);
      tbl[10] = mk(4'b1000, 6, 0, 0, 0, 4'h3, 4'h0, 4'b1000, 1'b0);
      tbl[11] = mk(4'b0110, 0, 1, 2, 0, 4'h0, 4'h7, 4'b0110, 1'b1);
      tbl[12] = mk(4'b0011, 0, 0, 4, 5, 4'h0, 4'h0, 4'b0001, 1'b1);
      tbl[13] = mk(4'b0011, 0, 0, 4, 5, 4'h0, 4'h0, 4'b0010, 1'b0);
      tbl[14] = mk(4'b1111, 2, 5, 2, 0, 4'h4, 4'h6, 4'b1001, 1'b0);
      tbl[15] = mk(4'b0110, 0, 5, 2, 0, 4'h0, 4'h6, 4'b0110, 1'b1);
      tbl[16] = mk(4'b0000, 0, 0, 0, 0, 4'h0, 4'h0, 4'b0000, 1'b1);
      tbl[17] = mk(4'b0000, 0, 0, 0, 0, 4'h0, 4'h0, 4'b0000, 1'b0);

      apply(idle);
      repeat (2) @(posedge clk);
      #1;
      sample();
      chk("rst_wr_en", {30'd0, ram_wr_en}, 0);
      chk("rst_wr_addr", {26'd0, ram_wr_addr}, 0);
      chk("rst_wr_data", {24'd0, ram_wr_data}, 0);
      chk("rst_rd_addr", {26'd0, ram_rd_addr}, 0);
      chk("rst_valid", {28'd0, ra_valid, rb_valid}, 0);
      advance();
      rst = 1'b0;

      // Preload every address through writer A.
      for (int i = 0; i < 8; i++) begin
         wa_req = 1'b1; wa_addr = 3'(i); wa_data = 4'(i) ^ 4'hC;
         sample();
         chk("preload_gnt", {24'd0, wa_gnt, wb_gnt, ra_gnt, rb_gnt}, 32'b11_00_00_00);
         advance();
      end

      for (int i = 0; i < 18; i++) begin
         apply(tbl[i]);
         sample();
         chk($sformatf("vec%0d_gnt_lat1", i), {28'd0, wa_gnt[0], wb_gnt[0], ra_gnt[0], rb_gnt[0]}, {28'd0, tbl[i].gnt});
         chk($sformatf("vec%0d_gnt_lat2", i), {28'd0, wa_gnt[1], wb_gnt[1], ra_gnt[1], rb_gnt[1]}, {28'd0, tbl[i].gnt});
         chk($sformatf("vec%0d_wr_en", i), {30'd0, ram_wr_en}, {30'd0, {2{tbl[i].wr_en}}});
         advance();
      end

      // Streaming reads of every address from both readers.
      apply(idle);
      ra_i = 0; rb_i = 0;
      ra_req = 1'b1; rb_req = 1'b1;
      for (int n = 0; n < 16; n++) begin
         sample();
         chk("stream_gnt", {28'd0, ra_gnt, rb_gnt}, (n % 2 == 0) ? 32'b0011 : 32'b1100);
         if (rb_gnt[0]) rb_i++;
         if (ra_gnt[0]) ra_i++;
         advance();
         ra_addr = 3'(ra_i); rb_addr = 3'(rb_i);
         ra_req = (ra_i < 8); rb_req = (rb_i < 8);
      end
      repeat (4) begin
         sample();
         advance();
      end

      // Reset with two reads in flight.
      ra_req = 1'b1; rb_req = 1'b1; ra_addr = 3'd3; rb_addr = 3'd4;
      sample(); advance();
      sample(); advance();
      rst = 1'b1; ra_req = 1'b0; rb_req = 1'b0;
      sample();
      chk("midrst_wr_en", {30'd0, ram_wr_en}, 0);
      chk("midrst_rd_addr", {26'd0, ram_rd_addr}, 0);
      chk("midrst_valid", {28'd0, ra_valid, rb_valid}, 0);
      advance();
      rst = 1'b0;
      for (int n = 0; n < 5; n++) begin
         sample();
         chk("post_rst_no_valid", {28'd0, ra_valid, rb_valid}, 0);
         advance();
      end

      // Both pointers favour A again after reset.
      apply(mk(4'b1111, 0, 1, 5, 6, 4'hA, 4'hB, 4'b0000, 1'b0));
      sample();
      chk("post_rst_rr", {24'd0, wa_gnt, wb_gnt, ra_gnt, rb_gnt}, 32'b11_00_11_00);
      advance();
      apply(idle);
      repeat (5) begin
         sample();
         advance();
      end
      chk("sb_drained", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err);
      $finish;
   end

endmodule
`default_nettype wire
